// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control unit: opcodes, FSM states
// and the bit layout of the internal control word.
package cpu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_STA = 4'h4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h8;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_E0   = 3'd4,
    S_E1   = 3'd5,
    S_E2   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam int CW_IR_LOAD     = 0;
  localparam int CW_PC_INC      = 1;
  localparam int CW_PC_LOAD     = 2;
  localparam int CW_PC_OUT      = 3;
  localparam int CW_MAR_LOAD    = 4;
  localparam int CW_MEM_RD      = 5;
  localparam int CW_MEM_WR      = 6;
  localparam int CW_OPERAND_OUT = 7;
  localparam int CW_A_LOAD      = 8;
  localparam int CW_A_OUT       = 9;
  localparam int CW_B_LOAD      = 10;
  localparam int CW_ALU_OUT     = 11;
  localparam int CW_ALU_SUB     = 12;
  localparam int CW_FLAGS_LOAD  = 13;
  localparam int CW_OUT_LOAD    = 14;
  localparam int CW_HALTED      = 15;
  localparam int CW_W           = 16;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/cpu_cu_decode.sv
// Combinational decode for the control sequencer: maps (state, opcode, flags, run)
// to the control word and the next FSM state.
module cpu_cu_decode
  import cpu_pkg::*;
#(
  parameter int OPCODE_W       = 4,
  parameter bit START_ON_RESET = 1'b0
) (
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_z,
  input  logic                flag_c,
  input  logic                run,
  output ctrl_word_t          ctrl,
  output state_t              next_state
);

  // Where every instruction goes once it finishes: straight into the next fetch, or pause.
  state_t done_state;
  assign done_state = run ? S_F0 : S_IDLE;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (run || START_ON_RESET) next_state = S_F0;
      S_F0:   next_state = S_F1;
      S_F1:   next_state = S_F2;
      S_F2:   next_state = S_E0;
      S_E0: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: next_state = S_E1;
          OP_HLT:                         next_state = S_HALT;
          default:                        next_state = done_state;
        endcase
      end
      S_E1: begin
        case (opcode)
          OP_ADD, OP_SUB: next_state = S_E2;
          default:        next_state = done_state;
        endcase
      end
      S_E2:   next_state = done_state;
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_F0: begin
        ctrl[CW_PC_OUT]   = 1'b1;
        ctrl[CW_MAR_LOAD] = 1'b1;
      end
      S_F1: begin
        ctrl[CW_MEM_RD]  = 1'b1;
        ctrl[CW_IR_LOAD] = 1'b1;
        ctrl[CW_PC_INC]  = 1'b1;
      end
      S_E0: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl[CW_OPERAND_OUT] = 1'b1;
            ctrl[CW_MAR_LOAD]    = 1'b1;
          end
          OP_LDI: begin
            ctrl[CW_OPERAND_OUT] = 1'b1;
            ctrl[CW_A_LOAD]      = 1'b1;
          end
          OP_JMP: begin
            ctrl[CW_OPERAND_OUT] = 1'b1;
            ctrl[CW_PC_LOAD]     = 1'b1;
          end
          OP_JZ: begin
            ctrl[CW_OPERAND_OUT] = 1'b1;
            ctrl[CW_PC_LOAD]     = flag_z;
          end
          OP_JC: begin
            ctrl[CW_OPERAND_OUT] = 1'b1;
            ctrl[CW_PC_LOAD]     = flag_c;
          end
          OP_OUT: begin
            ctrl[CW_A_OUT]    = 1'b1;
            ctrl[CW_OUT_LOAD] = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      S_E1: begin
        case (opcode)
          OP_LDA: begin
            ctrl[CW_MEM_RD] = 1'b1;
            ctrl[CW_A_LOAD] = 1'b1;
          end
          OP_STA: begin
            ctrl[CW_A_OUT]  = 1'b1;
            ctrl[CW_MEM_WR] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl[CW_MEM_RD] = 1'b1;
            ctrl[CW_B_LOAD] = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      S_E2: begin
        ctrl[CW_ALU_OUT]    = 1'b1;
        ctrl[CW_A_LOAD]     = 1'b1;
        ctrl[CW_FLAGS_LOAD] = 1'b1;
        ctrl[CW_ALU_SUB]    = (opcode == OP_SUB);
      end
      S_HALT: ctrl[CW_HALTED] = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control unit for the 8-bit accumulator CPU: state register,
// synchronous reset and fan-out of the decoded control word.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W       = 4,
  parameter bit START_ON_RESET = 1'b0
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_z,
  input  logic                flag_c,
  input  logic                run,
  output logic                ir_load,
  output logic                ir_clear,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                pc_out,
  output logic                mar_load,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                operand_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                alu_sub,
  output logic                flags_load,
  output logic                out_load,
  output logic                halted,
  output logic [2:0]          state_dbg
);

  state_t     state;
  state_t     next_state;
  ctrl_word_t ctrl;

  // clear_n wins over everything, including S_HALT and mid-instruction states.
  always_ff @(posedge clk) begin
    if (!clear_n) state <= S_IDLE;
    else          state <= next_state;
  end

  cpu_cu_decode #(
    .OPCODE_W      (OPCODE_W),
    .START_ON_RESET(START_ON_RESET)
  ) u_decode (
    .state     (state),
    .opcode    (opcode),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .run       (run),
    .ctrl      (ctrl),
    .next_state(next_state)
  );

  assign ir_clear    = ~clear_n;
  assign ir_load     = ctrl[CW_IR_LOAD];
  assign pc_inc      = ctrl[CW_PC_INC];
  assign pc_load     = ctrl[CW_PC_LOAD];
  assign pc_out      = ctrl[CW_PC_OUT];
  assign mar_load    = ctrl[CW_MAR_LOAD];
  assign mem_rd      = ctrl[CW_MEM_RD];
  assign mem_wr      = ctrl[CW_MEM_WR];
  assign operand_out = ctrl[CW_OPERAND_OUT];
  assign a_load      = ctrl[CW_A_LOAD];
  assign a_out       = ctrl[CW_A_OUT];
  assign b_load      = ctrl[CW_B_LOAD];
  assign alu_out     = ctrl[CW_ALU_OUT];
  assign alu_sub     = ctrl[CW_ALU_SUB];
  assign flags_load  = ctrl[CW_FLAGS_LOAD];
  assign out_load    = ctrl[CW_OUT_LOAD];
  assign halted      = ctrl[CW_HALTED];
  assign state_dbg   = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: an instruction-level model queues the
// expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       clear_n, flag_z, flag_c, run;
  logic [3:0] opcode;
  logic       ir_load, ir_clear, pc_inc, pc_load, pc_out, mar_load, mem_rd, mem_wr;
  logic       operand_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halted;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clear_n(clear_n), .opcode(opcode), .flag_z(flag_z), .flag_c(flag_c), .run(run),
    .ir_load(ir_load), .ir_clear(ir_clear), .pc_inc(pc_inc), .pc_load(pc_load), .pc_out(pc_out),
    .mar_load(mar_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .operand_out(operand_out),
    .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub),
    .flags_load(flags_load), .out_load(out_load), .halted(halted), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [2:0] st;
    logic ir_load, ir_clear, pc_inc, pc_load, pc_out, mar_load, mem_rd, mem_wr;
    logic operand_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halted;
  } tb_exp_t;

  tb_exp_t expq[$];
  int      vectors     = 0;
  int      miscompares = 0;
  bit      model_idle  = 1'b1;

  function automatic tb_exp_t mk(input logic [2:0] st);
    tb_exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic tb_exp_t sampleDut();
    tb_exp_t a;
    a = '{state_dbg, ir_load, ir_clear, pc_inc, pc_load, pc_out, mar_load, mem_rd, mem_wr,
          operand_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halted};
    return a;
  endfunction

  task automatic checkOutput(input tb_exp_t e);
    tb_exp_t a;
    int      drivers;
    a = sampleDut();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("[TB] FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a, e);
    end
    drivers = int'(pc_out) + int'(operand_out) + int'(a_out) + int'(alu_out) + int'(mem_rd);
    vectors++;
    if (drivers > 1) begin
      miscompares++;
      $display("[TB] FAIL bus_rule t=%0t actual=%0d drivers required<=1", $time, drivers);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) checkOutput(expq.pop_front());
  end

  // Inputs are already set for this cycle; record what the DUT must show, then advance.
  task automatic applyStimulus(input tb_exp_t e);
    e.ir_clear = ~clear_n;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idleFor(input int n);
    for (int i = 0; i < n; i++) begin
      run     = 1'b0;
      clear_n = 1'($urandom);
      opcode  = 4'($urandom);
      applyStimulus(mk(S_IDLE));
    end
    clear_n = 1'b1;
  endtask

  // One whole instruction as the programmer sees it; rst_at pulls clear_n low on that cycle index.
  task automatic doInstr(input logic [3:0] op, input logic fz, input logic fc,
                         input logic run_last, input int rst_at);
    tb_exp_t seq[$];
    tb_exp_t e;
    bit      is_mem;
    if (model_idle) begin
      run = 1'b1; clear_n = 1'b1; opcode = 4'($urandom);
      applyStimulus(mk(S_IDLE));
    end
    e = mk(S_F0); e.pc_out = 1; e.mar_load = 1; seq.push_back(e);
    e = mk(S_F1); e.mem_rd = 1; e.ir_load = 1; e.pc_inc = 1; seq.push_back(e);
    seq.push_back(mk(S_F2));
    is_mem = (op == 4'h1 || op == 4'h2 || op == 4'h3 || op == 4'h4);
    e = mk(S_E0);
    if (is_mem) begin e.operand_out = 1; e.mar_load = 1; end
    else if (op == 4'h5) begin e.operand_out = 1; e.a_load = 1; end
    else if (op == 4'h6) begin e.operand_out = 1; e.pc_load = 1; end
    else if (op == 4'h7) begin e.operand_out = 1; e.pc_load = fz; end
    else if (op == 4'h8) begin e.operand_out = 1; e.pc_load = fc; end
    else if (op == 4'hE) begin e.a_out = 1; e.out_load = 1; end
    seq.push_back(e);
    if (is_mem) begin
      e = mk(S_E1);
      if (op == 4'h1) begin e.mem_rd = 1; e.a_load = 1; end
      else if (op == 4'h4) begin e.a_out = 1; e.mem_wr = 1; end
      else begin e.mem_rd = 1; e.b_load = 1; end
      seq.push_back(e);
      if (op == 4'h2 || op == 4'h3) begin
        e = mk(S_E2); e.alu_out = 1; e.a_load = 1; e.flags_load = 1; e.alu_sub = (op == 4'h3);
        seq.push_back(e);
      end
    end
    for (int i = 0; i < seq.size(); i++) begin
      opcode  = (i >= 3) ? op : 4'($urandom);
      flag_z  = (i >= 3) ? fz : 1'($urandom);
      flag_c  = (i >= 3) ? fc : 1'($urandom);
      run     = (i == seq.size() - 1) ? run_last : 1'($urandom);
      clear_n = (i == rst_at) ? 1'b0 : 1'b1;
      applyStimulus(seq[i]);
      if (i == rst_at) begin
        clear_n    = 1'b1;
        model_idle = 1'b1;
        return;
      end
    end
    if (op == 4'hF) begin
      for (int i = 0; i < 10; i++) begin
        run = 1'($urandom); opcode = 4'($urandom);
        e = mk(S_HALT); e.halted = 1;
        applyStimulus(e);
      end
      clear_n = 1'b0;
      e = mk(S_HALT); e.halted = 1;
      applyStimulus(e);
      clear_n    = 1'b1;
      model_idle = 1'b1;
    end else begin
      model_idle = !run_last;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clear_n = 1'b0; run = 1'b0; opcode = 4'h0; flag_z = 1'b0; flag_c = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(mk(S_IDLE));
    clear_n = 1'b1;
    idleFor(2);
    model_idle = 1'b1;

    doInstr(4'h2, 1'b0, 1'b0, 1'b1, -1);
    doInstr(4'h7, 1'b0, 1'b0, 1'b1, -1);
    doInstr(4'h7, 1'b1, 1'b0, 1'b1, -1);
    doInstr(4'h3, 1'b0, 1'b1, 1'b1, 4);
    idleFor(2);
    doInstr(4'hF, 1'b0, 1'b0, 1'b1, -1);
    doInstr(4'h9, 1'b1, 1'b1, 1'b1, -1);
    doInstr(4'h2, 1'b0, 1'b0, 1'b0, -1);
    idleFor(3);
    doInstr(4'h0, 1'b0, 1'b0, 1'b1, -1);
    doInstr(4'h8, 1'b0, 1'b1, 1'b1, -1);
    doInstr(4'h8, 1'b1, 1'b0, 1'b1, -1);

    for (int n = 0; n < 60; n++) begin
      int rst_at;
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      if (model_idle) idleFor(int'($urandom_range(0, 2)));
      doInstr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), rst_at);
    end

    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain actual=%0d pending required=0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
